// File: rtl/alu_operand_issue.sv
// Decode / operand-issue stage feeding the ALU: decodes one instruction per cycle,
// reads the register file, stalls on scoreboard hazards and holds a registered operand bundle.
module alu_operand_issue #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int REG_AW     = $clog2(NUM_REGS)
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic [31:0]           instr_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  logic                  flush_i,
  output logic [REG_AW-1:0]     rf_rs1_addr_o,
  output logic [REG_AW-1:0]     rf_rs2_addr_o,
  input  logic [DATA_WIDTH-1:0] rf_rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rf_rs2_data_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output logic [1:0]            ex_func_o,
  output logic [5:0]            ex_imm_o,
  output logic [DATA_WIDTH-1:0] ex_rs1_data_o,
  output logic [DATA_WIDTH-1:0] ex_rs2_data_o,
  output logic [REG_AW-1:0]     ex_rd_o,
  input  logic                  wb_valid_i,
  input  logic [REG_AW-1:0]     wb_rd_i,
  output logic                  illegal_o
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;

  logic [3:0]          op;
  logic [REG_AW-1:0]   rd;
  logic [5:0]          imm;
  logic                legal;
  logic                hazard;
  logic                accept;
  logic                ex_fire;
  logic                unused_low_bits;

  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;
  logic                ex_valid_reg;
  logic                illegal_reg;
  logic [1:0]          func_reg;
  logic [5:0]          imm_reg;
  logic [DATA_WIDTH-1:0] rs1_data_reg;
  logic [DATA_WIDTH-1:0] rs2_data_reg;
  logic [REG_AW-1:0]   rd_reg;

  assign op            = instr_i[31:28];
  assign rd            = instr_i[27:23];
  assign rf_rs1_addr_o = instr_i[22:18];
  assign rf_rs2_addr_o = instr_i[17:13];
  assign imm           = instr_i[12:7];
  assign unused_low_bits = ^instr_i[6:0];

  assign legal = (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI);

  // Illegal opcodes are consumed regardless of the scoreboard.
  always_comb begin
    hazard = 1'b0;
    if (legal) begin
      hazard = busy_reg[rf_rs1_addr_o] || busy_reg[rd] ||
               ((op != OP_ADDI) && busy_reg[rf_rs2_addr_o]);
    end
  end

  assign instr_ready_o = arst_ni && !flush_i && !hazard && (!ex_valid_reg || ex_ready_i);
  assign accept        = instr_valid_i && instr_ready_o;
  assign ex_fire       = ex_valid_reg && ex_ready_i;

  // Clears first, then the issuing set, so a same-cycle set wins over a clear.
  always_comb begin
    busy_next = busy_reg;
    if (wb_valid_i) begin
      busy_next[wb_rd_i] = 1'b0;
    end
    if (flush_i && ex_valid_reg && !ex_ready_i) begin
      busy_next[rd_reg] = 1'b0;
    end
    if (accept && legal) begin
      busy_next[rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      busy_reg     <= '0;
      ex_valid_reg <= 1'b0;
      illegal_reg  <= 1'b0;
      func_reg     <= '0;
      imm_reg      <= '0;
      rs1_data_reg <= '0;
      rs2_data_reg <= '0;
      rd_reg       <= '0;
    end else begin
      busy_reg    <= busy_next;
      illegal_reg <= accept && !legal;
      if (accept && legal) begin
        ex_valid_reg <= 1'b1;
        func_reg     <= op[1:0];
        imm_reg      <= imm;
        rs1_data_reg <= rf_rs1_data_i;
        rs2_data_reg <= rf_rs2_data_i;
        rd_reg       <= rd;
      end else if (ex_fire || flush_i) begin
        ex_valid_reg <= 1'b0;
      end
    end
  end

  assign ex_valid_o    = ex_valid_reg;
  assign illegal_o     = illegal_reg;
  assign ex_func_o     = func_reg;
  assign ex_imm_o      = imm_reg;
  assign ex_rs1_data_o = rs1_data_reg;
  assign ex_rs2_data_o = rs2_data_reg;
  assign ex_rd_o       = rd_reg;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed bench for alu_operand_issue: register-file model, linear stimulus,
// immediate assertions against hand-computed expectations.
module tb_alu_operand_issue;

  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic [31:0] instr_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic        flush_i;
  logic [4:0]  rf_rs1_addr_o;
  logic [4:0]  rf_rs2_addr_o;
  logic [31:0] rf_rs1_data_i;
  logic [31:0] rf_rs2_data_i;
  logic        ex_valid_o;
  logic        ex_ready_i;
  logic [1:0]  ex_func_o;
  logic [5:0]  ex_imm_o;
  logic [31:0] ex_rs1_data_o;
  logic [31:0] ex_rs2_data_o;
  logic [4:0]  ex_rd_o;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        illegal_o;

  logic [31:0] rf [32];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  assign rf_rs1_data_i = rf[rf_rs1_addr_o];
  assign rf_rs2_data_i = rf[rf_rs2_addr_o];

  alu_operand_issue dut (
    .clk_i(clk_i), .arst_ni(arst_ni), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o), .flush_i(flush_i),
    .rf_rs1_addr_o(rf_rs1_addr_o), .rf_rs2_addr_o(rf_rs2_addr_o),
    .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .ex_func_o(ex_func_o),
    .ex_imm_o(ex_imm_o), .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
    .ex_rd_o(ex_rd_o), .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .illegal_o(illegal_o)
  );

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [5:0] imm);
    return {op, rd, rs1, rs2, imm, 7'h55};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are changed and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd100 + i;
    rf[0] = 32'd0; rf[1] = 32'd10; rf[2] = 32'd5;
    arst_ni = 1'b0; instr_i = '0; instr_valid_i = 1'b0; flush_i = 1'b0;
    ex_ready_i = 1'b1; wb_valid_i = 1'b0; wb_rd_i = '0;

    // Reset state
    tick(); tick();
    check("rst_ex_valid", ex_valid_o, 0);
    check("rst_illegal", illegal_o, 0);
    check("rst_func", ex_func_o, 0);
    check("rst_rs1", ex_rs1_data_o, 0);
    check("rst_rd", ex_rd_o, 0);
    check("rst_ready_low", instr_ready_o, 0);
    arst_ni = 1'b1;
    tick();

    // ADD r3 = r1 + r2
    instr_i = enc(4'h0, 5'd3, 5'd1, 5'd2, 6'h00); instr_valid_i = 1'b1;
    #1;
    check("add_ready", instr_ready_o, 1);
    check("rs1_addr", rf_rs1_addr_o, 1);
    check("rs2_addr", rf_rs2_addr_o, 2);
    tick();
    check("add_valid", ex_valid_o, 1);
    check("add_func", ex_func_o, 0);
    check("add_rs1", ex_rs1_data_o, 10);
    check("add_rs2", ex_rs2_data_o, 5);
    check("add_rd", ex_rd_o, 3);

    // ADDI r4 = r3 + imm stalls until the cycle after writeback of r3
    instr_i = enc(4'h2, 5'd4, 5'd3, 5'd0, 6'h3F);
    #1;
    check("raw_stall0", instr_ready_o, 0);
    tick();
    check("raw_drained", ex_valid_o, 0);
    check("raw_stall1", instr_ready_o, 0);
    wb_valid_i = 1'b1; wb_rd_i = 5'd3;
    #1;
    check("raw_no_bypass", instr_ready_o, 0);
    tick();
    wb_valid_i = 1'b0; rf[3] = 32'd15;
    #1;
    check("raw_release", instr_ready_o, 1);
    tick();
    check("addi_valid", ex_valid_o, 1);
    check("addi_func", ex_func_o, 2);
    check("addi_imm", ex_imm_o, 6'h3F);
    check("addi_rs1_new", ex_rs1_data_o, 15);
    check("addi_rd", ex_rd_o, 4);
    instr_valid_i = 1'b0; wb_valid_i = 1'b1; wb_rd_i = 5'd4;
    tick();
    wb_valid_i = 1'b0;
    check("addi_drained", ex_valid_o, 0);

    // Stream of four SUBs r10..r13 = r5 - r6 with 3 back-pressure cycles
    ex_ready_i = 1'b0;
    instr_i = enc(4'h1, 5'd10, 5'd5, 5'd6, 6'h00); instr_valid_i = 1'b1;
    #1;
    check("sub0_ready", instr_ready_o, 1);
    tick();
    instr_i = enc(4'h1, 5'd11, 5'd5, 5'd6, 6'h00);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("hold_ready", instr_ready_o, 0);
      check("hold_valid", ex_valid_o, 1);
      check("hold_rd", ex_rd_o, 10);
      check("hold_rs1", ex_rs1_data_o, 105);
      check("hold_func", ex_func_o, 1);
      if (c < 2) tick();
    end
    ex_ready_i = 1'b1;
    #1;
    check("stream_ready", instr_ready_o, 1);
    tick();
    check("sub1_rd", ex_rd_o, 11);
    check("sub1_rs2", ex_rs2_data_o, 106);
    instr_i = enc(4'h1, 5'd12, 5'd5, 5'd6, 6'h00);
    tick();
    check("sub2_rd", ex_rd_o, 12);
    check("sub2_valid", ex_valid_o, 1);
    instr_i = enc(4'h1, 5'd13, 5'd5, 5'd6, 6'h00);
    tick();
    check("sub3_rd", ex_rd_o, 13);
    instr_valid_i = 1'b0;
    tick();
    check("stream_drained", ex_valid_o, 0);

    // Illegal opcode reading a busy register is consumed without a stall
    instr_i = enc(4'hF, 5'd8, 5'd10, 5'd0, 6'h00); instr_valid_i = 1'b1;
    #1;
    check("ill_ready", instr_ready_o, 1);
    tick();
    instr_valid_i = 1'b0;
    check("ill_pulse", illegal_o, 1);
    check("ill_no_bundle", ex_valid_o, 0);
    tick();
    check("ill_pulse_end", illegal_o, 0);
    instr_i = enc(4'h0, 5'd8, 5'd1, 5'd2, 6'h00);
    #1;
    check("ill_no_set", instr_ready_o, 1);
    instr_i = enc(4'h0, 5'd1, 5'd10, 5'd2, 6'h00);
    #1;
    check("ill_keeps_busy", instr_ready_o, 0);

    // rd=0 never becomes busy
    instr_i = enc(4'h0, 5'd0, 5'd1, 5'd2, 6'h00); instr_valid_i = 1'b1;
    #1;
    check("rd0_ready", instr_ready_o, 1);
    tick();
    check("rd0_rd", ex_rd_o, 0);
    instr_i = enc(4'h0, 5'd5, 5'd0, 5'd0, 6'h00);
    #1;
    check("rs0_no_stall", instr_ready_o, 1);
    tick();
    check("rs0_rd", ex_rd_o, 5);
    check("rs0_data", ex_rs1_data_o, 0);
    instr_valid_i = 1'b0;
    tick();

    // Flush a held bundle to r7
    ex_ready_i = 1'b0;
    instr_i = enc(4'h0, 5'd7, 5'd1, 5'd2, 6'h00); instr_valid_i = 1'b1;
    tick();
    check("fl_held", ex_rd_o, 7);
    instr_valid_i = 1'b0; flush_i = 1'b1;
    #1;
    check("fl_ready_low", instr_ready_o, 0);
    tick();
    flush_i = 1'b0;
    check("fl_valid_clr", ex_valid_o, 0);
    instr_valid_i = 1'b1;
    #1;
    check("fl_busy_clr", instr_ready_o, 1);
    tick();
    check("fl_reissue", ex_valid_o, 1);
    instr_i = enc(4'h0, 5'd9, 5'd7, 5'd2, 6'h00);
    #1;
    check("pre_rst_stall", instr_ready_o, 0);

    // Asynchronous reset mid-stall
    arst_ni = 1'b0;
    #1;
    check("arst_valid", ex_valid_o, 0);
    check("arst_rd", ex_rd_o, 0);
    check("arst_rs1", ex_rs1_data_o, 0);
    check("arst_ready", instr_ready_o, 0);
    arst_ni = 1'b1; instr_valid_i = 1'b0;
    #1;
    check("arst_sb_clr7", instr_ready_o, 1);
    instr_i = enc(4'h0, 5'd1, 5'd10, 5'd2, 6'h00);
    #1;
    check("arst_sb_clr10", instr_ready_o, 1);
    tick();
    check("arst_idle", ex_valid_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_operand_issue.md
Name: alu_operand_issue

Overview:
- Decode/operand-issue stage directly upstream of the ALU math datapath.
- Accepts one instruction per cycle over a valid/ready handshake and decodes the op, destination, sources and 6-bit immediate.
- Reads the register file, blocks read-after-write and write-after-write hazards with a per-register busy scoreboard, and presents a registered operand bundle to the ALU stage.

Parameters:
- DATA_WIDTH, 32 (from simple_processor_pkg), operand width.
- NUM_REGS, 32, architectural register count; register 0 is hardwired zero.
- REG_AW, $clog2(NUM_REGS), register address width.

Ports:
- clk_i  in  1  clock, rising edge.
- arst_ni  in  1  asynchronous active-low reset.
- instr_i  in  32  instruction.
- instr_valid_i  in  1  instruction valid.
- instr_ready_o  out  1  stage can accept.
- flush_i  in  1  discard held bundle.
- rf_rs1_addr_o  out  REG_AW  equals instr_i[22:18], combinational.
- rf_rs2_addr_o  out  REG_AW  equals instr_i[17:13], combinational.
- rf_rs1_data_i  in  DATA_WIDTH  combinational RF read data for rf_rs1_addr_o.
- rf_rs2_data_i  in  DATA_WIDTH  combinational RF read data for rf_rs2_addr_o.
- ex_valid_o  out  1  operand bundle valid.
- ex_ready_i  in  1  ALU stage accepts.
- ex_func_o  out  2  0=ADD, 1=SUB, 2=ADDI.
- ex_imm_o  out  6  raw immediate; the ALU sign-extends it.
- ex_rs1_data_o  out  DATA_WIDTH  operand A.
- ex_rs2_data_o  out  DATA_WIDTH  operand B.
- ex_rd_o  out  REG_AW  destination register.
- wb_valid_i  in  1  writeback retiring.
- wb_rd_i  in  REG_AW  writeback destination.
- illegal_o  out  1  one-cycle pulse on an illegal opcode.

Behaviour:
- Encoding:
  - [31:28] op: 0x0 ADD, 0x1 SUB, 0x2 ADDI, all others illegal.
  - [27:23] rd, [22:18] rs1, [17:13] rs2, [12:7] imm.
  - [6:0] ignored.
- Reset (async, arst_ni=0): ex_valid_o=0, illegal_o=0, ex_func_o/ex_imm_o/ex_rs*_data_o/ex_rd_o=0, all busy bits=0.
- Hazard:
  - Asserted when busy[rs1], or busy[rs2] (ADD/SUB only; ADDI ignores rs2), or busy[rd].
  - busy[0] is always 0.
- instr_ready_o = arst_ni && !flush_i && !hazard && (!ex_valid_o || ex_ready_i).
  - Hazard is evaluated only for legal opcodes; an illegal opcode is never stalled by a hazard.
- Accept when instr_valid_i && instr_ready_o:
  - Legal op, at the next edge:
    - ex_valid_o=1.
    - The bundle is captured from the current instr_i and rf data (1-cycle latency).
    - busy[rd] is set unless rd=0.
  - Illegal op: the instruction is consumed, no bundle is issued, illegal_o=1 for exactly one cycle, and the scoreboard is unchanged.
- Output hold:
  - While ex_valid_o && !ex_ready_i, all ex_* outputs are stable.
  - ex_valid_o falls after a handshake unless a new bundle is accepted in the same cycle (back-to-back throughput of 1 per cycle).
- Writeback:
  - wb_valid_i clears busy[wb_rd_i] at the next edge.
  - The clear is not visible to the hazard check in the same cycle (no bypass): a dependent instruction issues one cycle after the writeback, and the RF then returns the new value.
  - If the same register is set and cleared in the same cycle, the set wins.
  - wb_rd_i=0 is ignored.
- Flush:
  - flush_i=1 forces instr_ready_o=0.
  - If ex_valid_o=1 and the bundle is not handshaking this cycle, ex_valid_o clears next edge and busy[ex_rd_o] is cleared (unless 0).
  - If the held bundle handshakes in the flush cycle, it is delivered and its busy bit stays set.
- Asynchronous reset mid-operation: the held bundle is dropped and the scoreboard is cleared immediately.

Test Plan:
- Reset, then ADD rd=3 rs1=1 rs2=2 with RF 10/5 and ex_ready_i=1 -> next cycle ex_valid_o=1, ex_func_o=0, ex_rs1_data_o=10, ex_rs2_data_o=5, ex_rd_o=3; busy[3]=1.
- ADDI rd=4 rs1=3 imm=6'h3F immediately after the ADD to r3 -> instr_ready_o=0 until the cycle after wb_valid_i with wb_rd_i=3; the bundle then issues with ex_imm_o=6'h3F.
- Streaming 4 independent SUBs with ex_ready_i held low for 3 cycles -> outputs stable while held, no loss or duplication, then 1 bundle per cycle.
- instr_i op=0xF -> consumed in one cycle, illegal_o pulses exactly 1 cycle, ex_valid_o stays 0, scoreboard unchanged.
- ADD rd=0 followed by ADD rs1=0 -> no stall; busy[0] never set.
- Held bundle rd=7 with ex_ready_i=0, then flush_i=1 -> ex_valid_o=0 next cycle, busy[7]=0, instr_ready_o=0 during the flush cycle; an arst_ni pulse mid-stall returns all outputs to reset values.
